// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - bounded up/down counter with wrap/saturate modes, wrap pulse, wrap count and sticky saturation flag
module mode_counter #(
  parameter int N      = 16,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [N-1:0]      D,
  input  logic              up,
  input  logic              sat,
  input  logic [N-1:0]      limit,
  output logic [N-1:0]      Q,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              sat_hit
);

  localparam logic [N-1:0]      ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] ONE_W  = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] MAX_W  = {WRAP_W{1'b1}};

  logic [N-1:0]      q_q, q_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              sat_hit_q, sat_hit_d;

  logic              at_top;
  logic              at_bot;
  logic              wrap_evt;

  // Boundary detection; a count left above a lowered limit counts as the top.
  always_comb begin
    at_top = (q_q >= limit);
    at_bot = (q_q == '0);
    tc     = enable & (up ? at_top : at_bot);
  end

  // Next-state: clear beats load beats enable; otherwise everything holds.
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    sat_hit_d  = sat_hit_q;
    wrap_evt   = 1'b0;
    if (clear) begin
      q_d        = '0;
      wrap_cnt_d = '0;
      sat_hit_d  = 1'b0;
    end else if (load) begin
      q_d = (D > limit) ? limit : D;
    end else if (enable) begin
      if (up) begin
        if (!at_top) begin
          q_d = q_q + ONE_N;
        end else if (sat) begin
          sat_hit_d = 1'b1;
        end else begin
          q_d      = '0;
          wrap_evt = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          q_d = q_q - ONE_N;
        end else if (sat) begin
          sat_hit_d = 1'b1;
        end else begin
          q_d      = limit;
          wrap_evt = 1'b1;
        end
      end
    end
    if (wrap_evt) begin
      wrap_d = 1'b1;
      if (wrap_cnt_q != MAX_W) begin
        wrap_cnt_d = wrap_cnt_q + ONE_W;
      end
    end
  end

  // State registers; reset also drops any pending wrap pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      sat_hit_q  <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      sat_hit_q  <= sat_hit_d;
    end
  end

  assign Q        = q_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign sat_hit  = sat_hit_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - self-checking bench for mode_counter
module tb_mode_counter;

  localparam int N  = 8;
  localparam int WW = 2;
  localparam int WC_MAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable, clear, load, up, sat;
  logic [N-1:0]  d_in, limit;
  logic [N-1:0]  q_out;
  logic          tc, wrap, sat_hit;
  logic [WW-1:0] wrap_cnt;

  int total = 0;
  int bad   = 0;

  // reference state
  int mq, mw, mwc, msh;

  typedef struct {
    bit clr, ld, en, up, sat, use_model;
    int d, lim;
    int q, tc, wrap, wc, sh;
  } vec_t;

  vec_t vecs[$];

  mode_counter #(.N(N), .WRAP_W(WW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .load(load),
    .D(d_in), .up(up), .sat(sat), .limit(limit),
    .Q(q_out), .tc(tc), .wrap(wrap), .wrap_cnt(wrap_cnt), .sat_hit(sat_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit clr, ld, en, u, s, input int d, lim,
                              input int q, t, w, wc, sh);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = u; v.sat = s; v.use_model = 1'b0;
    v.d = d; v.lim = lim; v.q = q; v.tc = t; v.wrap = w; v.wc = wc; v.sh = sh;
    return v;
  endfunction

  task automatic model_reset();
    mq = 0; mw = 0; mwc = 0; msh = 0;
  endtask

  // Reference: counts live in 0..lim; reaching past an edge either wraps
  // around the range (counted, pulsed) or is refused (sticky flag).
  task automatic model_step(input vec_t v, output int etc);
    int span;
    span = v.lim + 1;
    etc = (v.en && (v.up ? (mq >= v.lim) : (mq == 0))) ? 1 : 0;
    mw = 0;
    if (v.clr) begin
      mq = 0; mwc = 0; msh = 0;
    end else if (v.ld) begin
      mq = (v.d < v.lim) ? v.d : v.lim;
    end else if (v.en) begin
      if (etc == 1) begin
        if (v.sat) msh = 1;
        else begin
          mq  = v.up ? 0 : v.lim;
          mw  = 1;
          mwc = (mwc + 1 > WC_MAX) ? WC_MAX : mwc + 1;
        end
      end else begin
        mq = v.up ? (mq + 1) % span : mq - 1;
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int etc;
    model_step(v, etc);
    if (v.use_model) begin
      v.q = mq; v.tc = etc; v.wrap = mw; v.wc = mwc; v.sh = msh;
    end
    clear = v.clr; load = v.ld; enable = v.en; up = v.up; sat = v.sat;
    d_in = v.d[N-1:0]; limit = v.lim[N-1:0];
    #1;
    chk({tag, ".tc"}, int'(tc), v.tc);
    @(posedge clk);
    #1;
    chk({tag, ".q"},    int'(q_out),    v.q);
    chk({tag, ".wrap"}, int'(wrap),     v.wrap);
    chk({tag, ".wcnt"}, int'(wrap_cnt), v.wc);
    chk({tag, ".sat"},  int'(sat_hit),  v.sh);
  endtask

  initial begin
    vec_t v;
    rstn = 1'b0; enable = 0; clear = 0; load = 0; up = 0; sat = 0;
    d_in = '0; limit = '0;
    model_reset();
    #12;
    chk("rst.q", int'(q_out), 0);
    chk("rst.wrap", int'(wrap), 0);
    chk("rst.wcnt", int'(wrap_cnt), 0);
    chk("rst.sat", int'(sat_hit), 0);
    rstn = 1'b1;

    // wrap up, limit 9
    for (int k = 1; k <= 9; k++) vecs.push_back(mk(0,0,1,1,0, 0,9, k,0,0,0,0));
    vecs.push_back(mk(0,0,1,1,0, 0,9, 0,1,1,1,0));
    vecs.push_back(mk(0,0,1,1,0, 0,9, 1,0,0,1,0));
    vecs.push_back(mk(0,0,1,1,0, 0,9, 2,0,0,1,0));
    // saturate down from 3, limit 5
    vecs.push_back(mk(0,1,0,0,1, 3,5, 3,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,1, 0,5, 2,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,1, 0,5, 1,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,1, 0,5, 0,0,0,1,0));
    vecs.push_back(mk(0,0,1,0,1, 0,5, 0,1,0,1,1));
    vecs.push_back(mk(0,0,1,0,1, 0,5, 0,1,0,1,1));
    // priority and clamp
    vecs.push_back(mk(0,1,1,1,0, 20,15, 15,0,0,1,1));
    vecs.push_back(mk(1,1,1,1,0, 20,15, 0,1,0,0,0));
    // wrap_cnt saturation with limit 0
    vecs.push_back(mk(0,0,1,1,0, 0,0, 0,1,1,1,0));
    vecs.push_back(mk(0,0,1,1,0, 0,0, 0,1,1,2,0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0,0,1,1,0, 0,0, 0,1,1,3,0));
    // set up Q=7 with wrap pulse pending
    vecs.push_back(mk(1,0,0,0,0, 0,7, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 0,7, 7,1,1,1,0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset between edges while Q=7, wrap=1
    #1 rstn = 1'b0;
    #1;
    chk("arst.q", int'(q_out), 0);
    chk("arst.wrap", int'(wrap), 0);
    chk("arst.wcnt", int'(wrap_cnt), 0);
    chk("arst.sat", int'(sat_hit), 0);
    model_reset();
    #1 rstn = 1'b1;
    apply(mk(0,0,1,1,0, 0,7, 1,0,0,0,0), "post_rst");

    // runtime limit decrease below the count
    apply(mk(0,1,0,0,0, 12,15, 12,0,0,0,0), "lim_load");
    apply(mk(0,0,1,1,0, 0,8, 0,1,1,1,0), "lim_drop");
    apply(mk(0,0,0,1,0, 0,8, 0,0,0,1,0), "lim_hold");

    // randomized against the reference
    for (int i = 0; i < 600; i++) begin
      v.clr = ($urandom_range(0, 31) == 0);
      v.ld  = ($urandom_range(0, 7) == 0);
      v.en  = ($urandom_range(0, 3) != 0);
      v.up  = $urandom_range(0, 1);
      v.sat = ($urandom_range(0, 3) == 0);
      v.lim = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 10);
      v.d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      v.use_model = 1'b1;
      v.q = 0; v.tc = 0; v.wrap = 0; v.wc = 0; v.sh = 0;
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter N, default 16, meaning count/data width in bits (N >= 2).
REQ-002 SHALL have parameter WRAP_W, default 8, meaning width of wrap-event counter.
REQ-003 SHALL have port clk, input, 1, meaning single clock, all state updates on rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, meaning count step request for this cycle.
REQ-006 SHALL have port clear, input, 1, meaning synchronous clear of Q, wrap_cnt and sticky flag.
REQ-007 SHALL have port load, input, 1, meaning synchronous load of D into Q.
REQ-008 SHALL have port D, input, N, meaning load value.
REQ-009 SHALL have port up, input, 1, meaning direction (1 = increment, 0 = decrement).
REQ-010 SHALL have port sat, input, 1, meaning boundary mode (1 = saturate, 0 = wrap).
REQ-011 SHALL have port limit, input, N, meaning inclusive upper bound; count range 0..limit.
REQ-012 SHALL have port Q, output, N, meaning registered count value.
REQ-013 SHALL have port tc, output, 1, meaning combinational terminal count.
REQ-014 SHALL have port wrap, output, 1, meaning registered one-cycle pulse on wrap event.
REQ-015 SHALL have port wrap_cnt, output, WRAP_W, meaning registered number of wrap events.
REQ-016 SHALL have port sat_hit, output, 1, meaning registered sticky flag; set when a step is blocked by saturation.

Function
REQ-017 SHALL apply per-cycle priority clear > load > enable > hold.
REQ-018 SHALL on clear set Q=0, wrap=0, wrap_cnt=0, sat_hit=0, regardless of other inputs.
REQ-019 SHALL on load (no clear) set Q=min(D, limit); wrap=0; wrap_cnt and sat_hit unchanged.
REQ-020 SHALL on enable with up=1 and Q<limit set Q=Q+1.
REQ-021 SHALL on enable with up=0 and Q>0 set Q=Q-1.
REQ-022 SHALL on enable, up=1, Q>=limit, sat=0 set Q=0 and assert wrap for the next cycle.
REQ-023 SHALL on enable, up=0, Q==0, sat=0 set Q=limit and assert wrap for the next cycle.
REQ-024 SHALL on enable at a boundary with sat=1 hold Q, keep wrap=0 and set sat_hit=1.
REQ-025 SHALL, when Q>limit after a runtime limit decrease, treat Q as at the upper boundary (up: wrap to 0 or hold; down: Q-1 normally).
REQ-026 SHALL increment wrap_cnt by 1 on each wrap event, saturating at 2^WRAP_W-1.
REQ-027 SHALL deassert wrap in every cycle not immediately following a wrap event.
REQ-028 SHALL drive tc=1 iff enable=1 and (up=1 and Q>=limit, or up=0 and Q==0), independent of sat.
REQ-029 SHALL hold all registers when enable=0, load=0, clear=0.
REQ-030 SHALL, with limit=0, keep Q at 0; in wrap mode every enabled step is a wrap event.
REQ-031 SHALL perform all arithmetic modulo 2^N, with no carry beyond bit N-1.

Reset
REQ-032 SHALL on rstn=0 immediately force Q=0, wrap=0, wrap_cnt=0, sat_hit=0, independent of clk.
REQ-033 SHALL resume operation on the first rising clk edge after rstn deasserts, with no extra latency.
REQ-034 SHALL, when reset is asserted mid-count or mid-wrap pulse, discard the pending wrap pulse.

Verification
REQ-035 SHALL cover wrap up: limit=9, up=1, sat=0, enable 12 cycles from 0 -> Q 1..9,0,1,2; wrap pulse once, cycle after Q 9->0; wrap_cnt=1; tc=1 while Q=9.
REQ-036 SHALL cover saturate down: limit=5, load D=3, up=0, sat=1, enable 5 cycles -> Q 2,1,0,0,0; sat_hit=1 from the cycle after the first blocked step; wrap never asserts.
REQ-037 SHALL cover priority and clamp: load=1, D=20, limit=15, enable=1 -> Q=15; same cycle plus clear=1 -> Q=0, wrap_cnt=0.
REQ-038 SHALL cover wrap_cnt saturation: WRAP_W=2, limit=0, sat=0, enable 6 cycles -> wrap_cnt 1,2,3,3,3,3; Q stays 0.
REQ-039 SHALL cover async reset: rstn low between clock edges while Q=7 and wrap=1 -> all outputs 0 before the next edge; first enabled edge after release -> Q=1.
REQ-040 SHALL cover a runtime limit decrease: Q=12, limit changed to 8, up=1, sat=0, enable -> Q=0, wrap=1 next cycle.
